axil_arbiter_2to1: RTL and testbench

AXIL_ARBITER_2TO1 -- requirements
Module: axil_arbiter_2to1

---
 rtl/axil_arbiter_2to1_if.sv | 52 +++++
 rtl/axil_arbiter_2to1.sv | 208 ++++++++++++++++++++
 tb/tb_axil_arbiter_2to1.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_arbiter_2to1_if.sv
// -----------------------------------------------------------------------------
// axil_arbiter_2to1_if
// AXI-Lite signal bundle: AW, W, B, AR and R channels.
//
// Parameters
//   ADDR_WIDTH : AWADDR / ARADDR width
//   DATA_WIDTH : WDATA / RDATA width. WSTRB is DATA_WIDTH/8 bits wide.
//
// Modports
//   master : the side that issues transactions. It drives the address, write
//            data and the B/R READY signals, and receives the responses.
//   slave  : the side that accepts transactions. It drives the A/W READY
//            signals and the B/R responses.
// -----------------------------------------------------------------------------
interface axil_arbiter_2to1_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// axil_arbiter_2to1
// Two-requester AXI-Lite arbiter in front of a single AXI-Lite master port,
// which connects to the APB bridge. Only one transaction, read or write, is in
// flight at any time. When a transaction is granted, the granted port's
// channels are forwarded combinationally. The other port sees all of its
// READY and VALID outputs held low.
//
// Ports
//   ACLK    : clock. All logic runs on the rising edge.
//   ARESETn : asynchronous, active-low reset.
//   s0, s1  : requester ports (slave modport of axil_arbiter_2to1_if).
//   m       : shared master port (master modport of axil_arbiter_2to1_if).
//
// Build option
//   AXIL_ARB_ROUND_ROBIN_EN : when this macro is defined, simultaneous requests
//                             alternate between the ports using a last-grant
//                             pointer. When it is undefined, port 0 always wins.
// -----------------------------------------------------------------------------
module axil_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axil_arbiter_2to1_if.slave    s0,
    axil_arbiter_2to1_if.slave    s1,
    axil_arbiter_2to1_if.master   m
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RRESP = 3'd4
    } state_t;

    state_t state_reg;
    logic   gnt_reg;
    logic   aw_done_reg;
    logic   w_done_reg;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
    logic   last_gnt_reg;
`endif

    // ---------------------------------------------------------------------
    // Request decode and grant selection (only used in IDLE)
    // ---------------------------------------------------------------------
    logic wr_req0, wr_req1, req0, req1;
    logic pick_gnt, pick_wr;

    assign wr_req0 = s0.AWVALID & s0.WVALID;
    assign wr_req1 = s1.AWVALID & s1.WVALID;
    assign req0    = wr_req0 | s0.ARVALID;
    assign req1    = wr_req1 | s1.ARVALID;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    // On a tie, favour the port that was not granted last time.
    assign pick_gnt = (req0 & req1) ? ~last_gnt_reg : req1;
`else
    assign pick_gnt = ~req0;
`endif
    // A pending write on the chosen port takes precedence over its read.
    assign pick_wr = pick_gnt ? wr_req1 : wr_req0;

    // ---------------------------------------------------------------------
    // Forwarding windows
    // ---------------------------------------------------------------------
    logic in_waddr, in_wresp, in_raddr, in_rresp;
    logic fwd_aw, fwd_w;
    logic sel0, sel1;

    assign in_waddr = (state_reg == WADDR);
    assign in_wresp = (state_reg == WRESP);
    assign in_raddr = (state_reg == RADDR);
    assign in_rresp = (state_reg == RRESP);
    // After its own handshake, each write channel stays masked until the
    // other write channel completes.
    assign fwd_aw   = in_waddr & ~aw_done_reg;
    assign fwd_w    = in_waddr & ~w_done_reg;
    assign sel0     = ~gnt_reg;
    assign sel1     = gnt_reg;

    // Granted-port request signals
    logic [ADDR_WIDTH-1:0]   g_awaddr, g_araddr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic [DATA_WIDTH/8-1:0] g_wstrb;
    logic                    g_awvalid, g_wvalid, g_arvalid, g_bready, g_rready;

    assign g_awaddr  = gnt_reg ? s1.AWADDR  : s0.AWADDR;
    assign g_awvalid = gnt_reg ? s1.AWVALID : s0.AWVALID;
    assign g_wdata   = gnt_reg ? s1.WDATA   : s0.WDATA;
    assign g_wstrb   = gnt_reg ? s1.WSTRB   : s0.WSTRB;
    assign g_wvalid  = gnt_reg ? s1.WVALID  : s0.WVALID;
    assign g_bready  = gnt_reg ? s1.BREADY  : s0.BREADY;
    assign g_araddr  = gnt_reg ? s1.ARADDR  : s0.ARADDR;
    assign g_arvalid = gnt_reg ? s1.ARVALID : s0.ARVALID;
    assign g_rready  = gnt_reg ? s1.RREADY  : s0.RREADY;

    // ---------------------------------------------------------------------
    // Master-side outputs
    // ---------------------------------------------------------------------
    assign m.AWVALID = fwd_aw & g_awvalid;
    assign m.AWADDR  = fwd_aw ? g_awaddr : '0;
    assign m.WVALID  = fwd_w & g_wvalid;
    assign m.WDATA   = fwd_w ? g_wdata : '0;
    assign m.WSTRB   = fwd_w ? g_wstrb : '0;
    assign m.BREADY  = in_wresp & g_bready;
    assign m.ARVALID = in_raddr & g_arvalid;
    assign m.ARADDR  = in_raddr ? g_araddr : '0;
    assign m.RREADY  = in_rresp & g_rready;

    // ---------------------------------------------------------------------
    // Requester-side outputs. The non-granted port sees zeros.
    // ---------------------------------------------------------------------
    assign s0.AWREADY = sel0 & fwd_aw & m.AWREADY;
    assign s0.WREADY  = sel0 & fwd_w & m.WREADY;
    assign s0.BVALID  = sel0 & in_wresp & m.BVALID;
    assign s0.BRESP   = (sel0 & in_wresp) ? m.BRESP : 2'b00;
    assign s0.ARREADY = sel0 & in_raddr & m.ARREADY;
    assign s0.RVALID  = sel0 & in_rresp & m.RVALID;
    assign s0.RRESP   = (sel0 & in_rresp) ? m.RRESP : 2'b00;
    assign s0.RDATA   = (sel0 & in_rresp) ? m.RDATA : '0;

    assign s1.AWREADY = sel1 & fwd_aw & m.AWREADY;
    assign s1.WREADY  = sel1 & fwd_w & m.WREADY;
    assign s1.BVALID  = sel1 & in_wresp & m.BVALID;
    assign s1.BRESP   = (sel1 & in_wresp) ? m.BRESP : 2'b00;
    assign s1.ARREADY = sel1 & in_raddr & m.ARREADY;
    assign s1.RVALID  = sel1 & in_rresp & m.RVALID;
    assign s1.RRESP   = (sel1 & in_rresp) ? m.RRESP : 2'b00;
    assign s1.RDATA   = (sel1 & in_rresp) ? m.RDATA : '0;

    // ---------------------------------------------------------------------
    // Handshakes on the master port
    // ---------------------------------------------------------------------
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_done_next, w_done_next;

    assign aw_hs = m.AWVALID & m.AWREADY;
    assign w_hs  = m.WVALID & m.WREADY;
    assign b_hs  = in_wresp & m.BVALID & m.BREADY;
    assign ar_hs = m.ARVALID & m.ARREADY;
    assign r_hs  = in_rresp & m.RVALID & m.RREADY;

    assign aw_done_next = aw_done_reg | aw_hs;
    assign w_done_next  = w_done_reg | w_hs;

    // ---------------------------------------------------------------------
    // Arbitration FSM. Each completion returns to IDLE, so a new grant is
    // always separated from the previous transaction by at least one cycle.
    // ---------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg   <= IDLE;
            gnt_reg     <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
            last_gnt_reg <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt_reg     <= pick_gnt;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        state_reg   <= pick_wr ? WADDR : RADDR;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
                        last_gnt_reg <= pick_gnt;
`endif
                    end
                end
                WADDR: begin
                    if (aw_done_next && w_done_next) begin
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        state_reg   <= WRESP;
                    end else begin
                        aw_done_reg <= aw_done_next;
                        w_done_reg  <= w_done_next;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        state_reg <= IDLE;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        state_reg <= RRESP;
                    end
                end
                RRESP: begin
                    if (r_hs) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_axil_arbiter_2to1
// Directed bench for axil_arbiter_2to1. The bench drives both requester ports
// and plays the downstream AXI-Lite slave. It prints one line per transaction.
// Expected grant order depends on AXIL_ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_axil_arbiter_2to1;

    logic ACLK = 1'b0;
    logic ARESETn;

    always #5 ACLK = ~ACLK;

    axil_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_if ();
    axil_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1_if ();
    axil_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

    axil_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if)
    );

    // Per-port views of the DUT outputs, indexed by port number.
    logic [1:0]  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp [2];
    logic [1:0]  s_rresp [2];
    logic [31:0] s_rdata [2];

    assign s_awready  = {s1_if.AWREADY, s0_if.AWREADY};
    assign s_wready   = {s1_if.WREADY,  s0_if.WREADY};
    assign s_bvalid   = {s1_if.BVALID,  s0_if.BVALID};
    assign s_arready  = {s1_if.ARREADY, s0_if.ARREADY};
    assign s_rvalid   = {s1_if.RVALID,  s0_if.RVALID};
    assign s_bresp[0] = s0_if.BRESP;
    assign s_bresp[1] = s1_if.BRESP;
    assign s_rresp[0] = s0_if.RRESP;
    assign s_rresp[1] = s1_if.RRESP;
    assign s_rdata[0] = s0_if.RDATA;
    assign s_rdata[1] = s1_if.RDATA;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    task automatic drive_aw(input logic p, input logic v, input logic [31:0] a);
        if (p == 1'b0) begin s0_if.AWVALID = v; s0_if.AWADDR = a; end
        else           begin s1_if.AWVALID = v; s1_if.AWADDR = a; end
    endtask

    task automatic drive_w(input logic p, input logic v, input logic [31:0] d);
        if (p == 1'b0) begin s0_if.WVALID = v; s0_if.WDATA = d; s0_if.WSTRB = 4'hF; end
        else           begin s1_if.WVALID = v; s1_if.WDATA = d; s1_if.WSTRB = 4'hF; end
    endtask

    task automatic drive_ar(input logic p, input logic v, input logic [31:0] a);
        if (p == 1'b0) begin s0_if.ARVALID = v; s0_if.ARADDR = a; end
        else           begin s1_if.ARVALID = v; s1_if.ARADDR = a; end
    endtask

    task automatic drive_rdy(input logic p, input logic br, input logic rr);
        if (p == 1'b0) begin s0_if.BREADY = br; s0_if.RREADY = rr; end
        else           begin s1_if.BREADY = br; s1_if.RREADY = rr; end
    endtask

    // Full write from port p. The downstream slave accepts W w_lag cycles after AW.
    task automatic write_txn(input logic p, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, input int w_lag);
        drive_aw(p, 1'b1, addr);
        drive_w(p, 1'b1, data);
        drive_rdy(p, 1'b1, 1'b0);
        #1;
        check_val("wr_pregrant_awvalid", 32'(m_if.AWVALID), 32'd0);
        step();
        #1;
        check_val("wr_m_awvalid", 32'(m_if.AWVALID), 32'd1);
        check_val("wr_m_awaddr", m_if.AWADDR, addr);
        check_val("wr_m_wvalid", 32'(m_if.WVALID), 32'd1);
        check_val("wr_m_wdata", m_if.WDATA, data);
        check_val("wr_m_arvalid", 32'(m_if.ARVALID), 32'd0);
        check_val("wr_other_awready", 32'(s_awready[~p]), 32'd0);
        m_if.AWREADY = 1'b1;
        if (w_lag == 0) m_if.WREADY = 1'b1;
        #1;
        check_val("wr_awready", 32'(s_awready[p]), 32'd1);
        check_val("wr_other_awready_hs", 32'(s_awready[~p]), 32'd0);
        check_val("wr_other_wready_hs", 32'(s_wready[~p]), 32'd0);
        if (w_lag == 0) check_val("wr_wready", 32'(s_wready[p]), 32'd1);
        step();
        m_if.AWREADY = 1'b0;
        drive_aw(p, 1'b0, 32'h0);
        if (w_lag > 0) begin
            for (int i = 1; i < w_lag; i++) begin
                #1;
                check_val("wr_lag_awvalid", 32'(m_if.AWVALID), 32'd0);
                check_val("wr_lag_wvalid", 32'(m_if.WVALID), 32'd1);
                check_val("wr_lag_bready", 32'(m_if.BREADY), 32'd0);
                step();
            end
            m_if.WREADY = 1'b1;
            #1;
            check_val("wr_lag_wready", 32'(s_wready[p]), 32'd1);
            check_val("wr_lag_awvalid_hs", 32'(m_if.AWVALID), 32'd0);
            step();
        end
        m_if.WREADY = 1'b0;
        drive_w(p, 1'b0, 32'h0);
        m_if.BVALID = 1'b1;
        m_if.BRESP  = resp;
        #1;
        check_val("wr_m_wvalid_done", 32'(m_if.WVALID), 32'd0);
        check_val("wr_bvalid", 32'(s_bvalid[p]), 32'd1);
        check_val("wr_bresp", 32'(s_bresp[p]), 32'(resp));
        check_val("wr_other_bvalid", 32'(s_bvalid[~p]), 32'd0);
        check_val("wr_m_bready", 32'(m_if.BREADY), 32'd1);
        step();
        m_if.BVALID = 1'b0;
        m_if.BRESP  = 2'b00;
        drive_rdy(p, 1'b0, 1'b0);
        #1;
        check_val("wr_bvalid_after", 32'(s_bvalid[p]), 32'd0);
        check_val("wr_idle_awvalid", 32'(m_if.AWVALID), 32'd0);
        $display("write S%0d addr=0x%08h data=0x%08h bresp=%0d w_lag=%0d", p, addr, data, resp, w_lag);
    endtask

    // Full read from port p. The downstream slave returns rdata and resp.
    task automatic read_txn(input logic p, input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [1:0] resp);
        drive_ar(p, 1'b1, addr);
        drive_rdy(p, 1'b0, 1'b1);
        #1;
        check_val("rd_pregrant_arvalid", 32'(m_if.ARVALID), 32'd0);
        step();
        #1;
        check_val("rd_m_arvalid", 32'(m_if.ARVALID), 32'd1);
        check_val("rd_m_araddr", m_if.ARADDR, addr);
        check_val("rd_m_awvalid", 32'(m_if.AWVALID), 32'd0);
        m_if.ARREADY = 1'b1;
        #1;
        check_val("rd_arready", 32'(s_arready[p]), 32'd1);
        check_val("rd_other_arready", 32'(s_arready[~p]), 32'd0);
        step();
        m_if.ARREADY = 1'b0;
        drive_ar(p, 1'b0, 32'h0);
        m_if.RVALID = 1'b1;
        m_if.RDATA  = rdata;
        m_if.RRESP  = resp;
        #1;
        check_val("rd_rvalid", 32'(s_rvalid[p]), 32'd1);
        check_val("rd_rdata", s_rdata[p], rdata);
        check_val("rd_rresp", 32'(s_rresp[p]), 32'(resp));
        check_val("rd_other_rvalid", 32'(s_rvalid[~p]), 32'd0);
        check_val("rd_other_rdata", s_rdata[~p], 32'h0);
        check_val("rd_m_rready", 32'(m_if.RREADY), 32'd1);
        step();
        m_if.RVALID = 1'b0;
        m_if.RDATA  = 32'h0;
        m_if.RRESP  = 2'b00;
        drive_rdy(p, 1'b0, 1'b0);
        #1;
        check_val("rd_rvalid_after", 32'(s_rvalid[p]), 32'd0);
        $display("read  S%0d addr=0x%08h rdata=0x%08h rresp=%0d", p, addr, rdata, resp);
    endtask

    task automatic apply_reset();
        ARESETn = 1'b0;
        step();
        step();
        ARESETn = 1'b1;
        step();
    endtask

    initial begin
        logic [3:0]  order;
        int          rem [2];
        logic        ep;
        logic [31:0] exp_addr;

        ARESETn = 1'b0;
        for (int p = 0; p < 2; p++) begin
            drive_aw(p[0], 1'b0, 32'h0);
            drive_w(p[0], 1'b0, 32'h0);
            drive_ar(p[0], 1'b0, 32'h0);
            drive_rdy(p[0], 1'b0, 1'b0);
        end
        m_if.AWREADY = 1'b0; m_if.WREADY = 1'b0;
        m_if.BVALID = 1'b0;  m_if.BRESP = 2'b00;
        m_if.ARREADY = 1'b0;
        m_if.RVALID = 1'b0;  m_if.RDATA = 32'h0; m_if.RRESP = 2'b00;

        // Requests are ignored while reset is held.
        drive_aw(1'b0, 1'b1, 32'h4);
        drive_w(1'b0, 1'b1, 32'h1234);
        step();
        step();
        #1;
        check_val("rst_m_awvalid", 32'(m_if.AWVALID), 32'd0);
        check_val("rst_m_wvalid", 32'(m_if.WVALID), 32'd0);
        check_val("rst_s0_awready", 32'(s_awready[0]), 32'd0);
        check_val("rst_s0_bresp", 32'(s_bresp[0]), 32'd0);
        check_val("rst_s1_rdata", s_rdata[1], 32'h0);
        drive_aw(1'b0, 1'b0, 32'h0);
        drive_w(1'b0, 1'b0, 32'h0);
        ARESETn = 1'b1;
        step();

        // S0 write, downstream accepts AW and W together
        write_txn(1'b0, 32'h004, 32'hDEADBEEF, 2'b00, 0);
        // S1 write, W accepted two cycles after AW
        write_txn(1'b1, 32'h018, 32'h0BADF00D, 2'b00, 2);
        // S1 read answered with SLVERR
        read_txn(1'b1, 32'h010, 32'hCAFEF00D, 2'b10);
        // S0 with write and read pending together: the write goes first
        drive_ar(1'b0, 1'b1, 32'h014);
        write_txn(1'b0, 32'h00C, 32'h55AA55AA, 2'b10, 0);
        read_txn(1'b0, 32'h014, 32'h01020304, 2'b00);

        // Simultaneous reads, two per port, starting from reset state
        apply_reset();
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        order = 4'b1010;
`else
        order = 4'b1100;
`endif
        rem[0] = 2;
        rem[1] = 2;
        drive_ar(1'b0, 1'b1, 32'h008);
        drive_ar(1'b1, 1'b1, 32'h00C);
        drive_rdy(1'b0, 1'b0, 1'b1);
        drive_rdy(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ep = order[k];
            exp_addr = ep ? 32'h00C : 32'h008;
            #1;
            check_val("arb_idle_arvalid", 32'(m_if.ARVALID), 32'd0);
            step();
            #1;
            check_val("arb_m_araddr", m_if.ARADDR, exp_addr);
            m_if.ARREADY = 1'b1;
            #1;
            check_val("arb_arready", 32'(s_arready[ep]), 32'd1);
            check_val("arb_other_arready", 32'(s_arready[~ep]), 32'd0);
            step();
            m_if.ARREADY = 1'b0;
            rem[ep] = rem[ep] - 1;
            if (rem[ep] == 0) drive_ar(ep, 1'b0, 32'h0);
            m_if.RVALID = 1'b1;
            m_if.RDATA  = 32'hA000_0000 + 32'(k);
            #1;
            check_val("arb_rvalid", 32'(s_rvalid[ep]), 32'd1);
            check_val("arb_other_rvalid", 32'(s_rvalid[~ep]), 32'd0);
            check_val("arb_rdata", s_rdata[ep], 32'hA000_0000 + 32'(k));
            step();
            m_if.RVALID = 1'b0;
            m_if.RDATA  = 32'h0;
            $display("arb   grant %0d -> S%0d addr=0x%08h", k, ep, exp_addr);
        end
        drive_rdy(1'b0, 1'b0, 1'b0);
        drive_rdy(1'b1, 1'b0, 1'b0);

        // Reset while waiting for the write response
        drive_aw(1'b0, 1'b1, 32'h020);
        drive_w(1'b0, 1'b1, 32'h11112222);
        drive_rdy(1'b0, 1'b1, 1'b0);
        step();
        m_if.AWREADY = 1'b1;
        m_if.WREADY  = 1'b1;
        step();
        m_if.AWREADY = 1'b0;
        m_if.WREADY  = 1'b0;
        drive_aw(1'b0, 1'b0, 32'h0);
        drive_w(1'b0, 1'b0, 32'h0);
        m_if.BVALID = 1'b1;
        #1;
        check_val("rstw_bvalid_pre", 32'(s_bvalid[0]), 32'd1);
        ARESETn = 1'b0;
        #1;
        check_val("rstw_s0_bvalid", 32'(s_bvalid[0]), 32'd0);
        check_val("rstw_s1_bvalid", 32'(s_bvalid[1]), 32'd0);
        check_val("rstw_m_bready", 32'(m_if.BREADY), 32'd0);
        step();
        check_val("rstw_s0_bvalid_held", 32'(s_bvalid[0]), 32'd0);
        ARESETn = 1'b1;
        m_if.BVALID = 1'b0;
        drive_rdy(1'b0, 1'b0, 1'b0);
        step();
        $display("reset abandoned S0 write in response phase");
        read_txn(1'b1, 32'h024, 32'h87654321, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
